coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor_pkg.sv | 32 +++
 rtl/sensor_debounce.sv | 51 +++++
 rtl/coin_acceptor.sv | 153 +++++++++++++++
 tb/tb_coin_acceptor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// Shared coin codes and emitter state encodings for the coin path and the vending FSM.
// Also holds the width-to-coin classification rule.
package coin_acceptor_pkg;

    typedef enum logic [1:0] {
        COIN_NONE  = 2'b00,
        COIN_SMALL = 2'b01,
        COIN_LARGE = 2'b10
    } coin_code_t;

    typedef enum logic [1:0] {
        EMIT_IDLE = 2'b00,
        EMIT_SEND = 2'b01,
        EMIT_GAP  = 2'b10
    } emit_state_t;

    // COIN_NONE means the width falls outside both coin ranges and must be rejected.
    function automatic coin_code_t classify_width(input int width,
                                                  input int small_min,
                                                  input int small_max,
                                                  input int large_min,
                                                  input int large_max);
        if (width >= small_min && width <= small_max) begin
            return COIN_SMALL;
        end
        if (width >= large_min && width <= large_max) begin
            return COIN_LARGE;
        end
        return COIN_NONE;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for the coin slot sensor.
// The debounced level moves only after DEB_CYCLES agreeing samples in a row.
module sensor_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic sensor_i,
    output logic deb_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A sample that matches the current level restarts the run of mismatches.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced sensor, pulse-width classifier, small coin FIFO and a
// rate-limited emitter that hands one-cycle coin codes to the vending FSM.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int SMALL_MIN  = 8,
    parameter int SMALL_MAX  = 15,
    parameter int LARGE_MIN  = 16,
    parameter int LARGE_MAX  = 31,
    parameter int MIN_GAP    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sensor,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy
);

    localparam int WIDTH_W = $clog2(LARGE_MAX + 2);
    localparam logic [WIDTH_W-1:0] WIDTH_SAT = WIDTH_W'(LARGE_MAX + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);

    logic               deb;
    logic               deb_prev_q;
    logic               fall;
    logic [WIDTH_W-1:0] width_q;
    logic [WIDTH_W-1:0] width_d;
    coin_code_t         cls_result;
    logic               cls_valid_q;
    logic               cls_bad_q;
    coin_code_t         cls_code_q;
    logic               reject_q;
    coin_code_t         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q;
    logic [PTR_W:0]     rd_ptr_q;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;
    emit_state_t        state_q;
    logic [GAP_W-1:0]   gap_q;
    coin_code_t         coin_q;

    sensor_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rstn     (rstn),
        .sensor_i (sensor),
        .deb_o    (deb)
    );

    assign fall       = deb_prev_q & ~deb;
    assign cls_result = classify_width(int'(width_q), SMALL_MIN, SMALL_MAX, LARGE_MIN, LARGE_MAX);

    // On the first debounced-high cycle the count restarts at 1, so at the fall it equals the high time.
    always_comb begin
        width_d = width_q;
        if (deb) begin
            if (!deb_prev_q) begin
                width_d = WIDTH_W'(1);
            end else if (width_q != WIDTH_SAT) begin
                width_d = width_q + 1'b1;
            end
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop   = (state_q == EMIT_IDLE) && !empty;
    assign push  = cls_valid_q && (!full || pop);
    assign drop  = cls_valid_q && full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deb_prev_q  <= 1'b0;
            width_q     <= '0;
            cls_valid_q <= 1'b0;
            cls_bad_q   <= 1'b0;
            cls_code_q  <= COIN_NONE;
            reject_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            deb_prev_q  <= deb;
            width_q     <= width_d;
            cls_valid_q <= fall && (cls_result != COIN_NONE);
            cls_bad_q   <= fall && (cls_result == COIN_NONE);
            cls_code_q  <= cls_result;
            reject_q    <= cls_bad_q | drop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read while the pointers say it is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= cls_code_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMIT_IDLE;
            gap_q   <= '0;
            coin_q  <= COIN_NONE;
        end else begin
            case (state_q)
                EMIT_IDLE: begin
                    if (pop) begin
                        coin_q  <= fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
                        state_q <= EMIT_SEND;
                    end else begin
                        coin_q  <= COIN_NONE;
                    end
                end
                EMIT_SEND: begin
                    coin_q  <= COIN_NONE;
                    gap_q   <= '0;
                    state_q <= EMIT_GAP;
                end
                EMIT_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= EMIT_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    coin_q  <= COIN_NONE;
                    state_q <= EMIT_IDLE;
                end
            endcase
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign busy   = deb | !empty | (state_q != EMIT_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Scenario bench for coin_acceptor: expected codes are queued as pulses are driven and
// compared against the codes a negedge monitor collects from the DUT.
module tb_coin_acceptor;
    import coin_acceptor_pkg::*;

    localparam int TB_GAP = 100;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sensor = 1'b0;
    logic [1:0] coin;
    logic       reject;
    logic       busy;

    int         cyc = 0;
    int         rej_cnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    int         obs_cyc_q[$];
    logic [1:0] got;
    logic [1:0] req;

    coin_acceptor #(
        .DEB_CYCLES (4),
        .SMALL_MIN  (8),
        .SMALL_MAX  (15),
        .LARGE_MIN  (16),
        .LARGE_MAX  (31),
        .MIN_GAP    (TB_GAP),
        .FIFO_DEPTH (4)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sensor (sensor),
        .coin   (coin),
        .reject (reject),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rstn) begin
            if (coin !== 2'b00) begin
                obs_q.push_back(coin);
                obs_cyc_q.push_back(cyc);
                $display("[%0d] coin code %0d", cyc, coin);
            end
            if (reject === 1'b1) begin
                rej_cnt++;
                $display("[%0d] reject pulse", cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A pulse of len cycles; start is the cycle count at the moment sensor went high.
    task automatic drive_pulse(input int len, output int start);
        @(posedge clk);
        #1;
        sensor = 1'b1;
        start  = cyc;
        repeat (len) @(posedge clk);
        #1;
        sensor = 1'b0;
    endtask

    task automatic test_reset();
        int start;
        int rej0;
        tick(2);
        n_cmp++; if (coin !== 2'b00) begin n_err++; $display("FAIL reset_coin: got %0d, required 0", coin); end
        n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL reset_reject: got %0b, required 0", reject); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        sensor = 1'b1;
        tick(3);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_sensor_high: got %0b, required 0", busy); end
        rej0  = rej_cnt;
        rstn  = 1'b1;
        start = cyc;
        repeat (12) @(posedge clk);
        #1;
        sensor = 1'b0;
        exp_q.push_back(COIN_SMALL);
        tick(40);
        n_cmp++;
        if (obs_cyc_q.size() < 1 || obs_cyc_q[0] != start + 21) begin
            n_err++;
            $display("FAIL reset_release_latency: got cycle %0d, required %0d",
                     (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, start + 21);
        end
        n_cmp++; if (rej_cnt != rej0) begin n_err++; $display("FAIL reset_release_reject: got %0d, required %0d", rej_cnt - rej0, 0); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL reset_release_count: got %0d codes, required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); req = exp_q.pop_front(); n_cmp++;
            if (got !== req) begin n_err++; $display("FAIL reset_release_code: got %0d, required %0d", got, req); end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
        tick(100);
    endtask

    task automatic test_small();
        int start;
        int rej0;
        rej0 = rej_cnt;
        drive_pulse(12, start);
        exp_q.push_back(COIN_SMALL);
        tick(30);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL small_busy_gap: got %0b, required 1", busy); end
        n_cmp++;
        if (obs_cyc_q.size() < 1 || obs_cyc_q[0] != start + 21) begin
            n_err++;
            $display("FAIL small_latency: got cycle %0d, required %0d",
                     (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, start + 21);
        end
        tick(120);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL small_busy_idle: got %0b, required 0", busy); end
        n_cmp++; if (rej_cnt != rej0) begin n_err++; $display("FAIL small_reject: got %0d, required 0", rej_cnt - rej0); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL small_count: got %0d codes, required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); req = exp_q.pop_front(); n_cmp++;
            if (got !== req) begin n_err++; $display("FAIL small_code: got %0d, required %0d", got, req); end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_widths();
        int         widths [9] = '{3, 5, 7, 8, 15, 16, 31, 32, 40};
        logic [1:0] codes  [9] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
        int         rejs   [9] = '{0, 1, 1, 0, 0, 0, 0, 1, 1};
        int         start;
        int         rej0;
        for (int i = 0; i < 9; i++) begin
            rej0 = rej_cnt;
            drive_pulse(widths[i], start);
            if (codes[i] != 2'b00) exp_q.push_back(codes[i]);
            tick(150);
            n_cmp++;
            if (rej_cnt - rej0 != rejs[i]) begin
                n_err++;
                $display("FAIL width_%0d_reject: got %0d pulses, required %0d", widths[i], rej_cnt - rej0, rejs[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL widths_count: got %0d codes, required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); req = exp_q.pop_front(); n_cmp++;
            if (got !== req) begin n_err++; $display("FAIL widths_code: got %0d, required %0d", got, req); end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_glitch();
        int rej0;
        rej0 = rej_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            sensor = (i == 5 || i == 9) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        sensor = 1'b0;
        exp_q.push_back(COIN_SMALL);
        tick(150);
        n_cmp++; if (rej_cnt != rej0) begin n_err++; $display("FAIL glitch_reject: got %0d, required 0", rej_cnt - rej0); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL glitch_count: got %0d codes, required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); req = exp_q.pop_front(); n_cmp++;
            if (got !== req) begin n_err++; $display("FAIL glitch_code: got %0d, required %0d", got, req); end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    // Coins arrive far faster than the emitter drains: one goes straight out, four fill
    // the buffer and the sixth finds it full.
    task automatic test_back_to_back();
        int         widths [6] = '{9, 17, 9, 17, 9, 17};
        logic [1:0] codes  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        int         start;
        int         rej0;
        rej0 = rej_cnt;
        for (int i = 0; i < 6; i++) begin
            drive_pulse(widths[i], start);
            if (i < 5) exp_q.push_back(codes[i]);
            tick(4);
        end
        tick(600);
        n_cmp++; if (rej_cnt - rej0 != 1) begin n_err++; $display("FAIL b2b_reject: got %0d pulses, required 1", rej_cnt - rej0); end
        for (int i = 1; i < obs_cyc_q.size(); i++) begin
            n_cmp++;
            if (obs_cyc_q[i] - obs_cyc_q[i-1] != TB_GAP + 2) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d cycles, required %0d", obs_cyc_q[i] - obs_cyc_q[i-1], TB_GAP + 2);
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d codes, required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); req = exp_q.pop_front(); n_cmp++;
            if (got !== req) begin n_err++; $display("FAIL b2b_code: got %0d, required %0d", got, req); end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_reset_mid_send();
        int start;
        int rej0;
        int waited;
        for (int i = 0; i < 5; i++) begin
            drive_pulse(9, start);
            if (i < 2) exp_q.push_back(COIN_SMALL);
            tick(4);
        end
        waited = 0;
        while (obs_q.size() < 2 && waited < 400) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_cmp++;
        if (obs_q.size() < 2) begin
            n_err++;
            $display("FAIL midsend_timeout: got %0d codes, required 2", obs_q.size());
        end
        rstn = 1'b0;
        #1;
        n_cmp++; if (coin !== 2'b00) begin n_err++; $display("FAIL midsend_coin: got %0d, required 0", coin); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midsend_busy: got %0b, required 0", busy); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL midsend_count: got %0d codes, required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); req = exp_q.pop_front(); n_cmp++;
            if (got !== req) begin n_err++; $display("FAIL midsend_code: got %0d, required %0d", got, req); end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
        tick(3);
        rstn = 1'b1;
        rej0 = rej_cnt;
        tick(300);
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL after_reset_codes: got %0d codes, required 0", obs_q.size()); end
        n_cmp++; if (rej_cnt != rej0) begin n_err++; $display("FAIL after_reset_reject: got %0d, required 0", rej_cnt - rej0); end
        obs_q.delete(); obs_cyc_q.delete();
        drive_pulse(20, start);
        exp_q.push_back(COIN_LARGE);
        tick(60);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL new_coin_count: got %0d codes, required %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); req = exp_q.pop_front(); n_cmp++;
            if (got !== req) begin n_err++; $display("FAIL new_coin_code: got %0d, required %0d", got, req); end
        end
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete();
    endtask

    initial begin
        test_reset();
        test_small();
        test_widths();
        test_glitch();
        test_back_to_back();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
